clk_period_meter: RTL and testbench

CLK_PERIOD_METER -- requirements
Module: clk_period_meter

---
 rtl/clk_meter_pkg.sv | 14 +
 rtl/clk_edge_sync.sv | 30 +++
 rtl/clk_period_meter.sv | 153 +++++++++++++++
 tb/tb_clk_period_meter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_meter_pkg.sv
// Shared types and default parameters for the clk_in period/high-time meter.
package clk_meter_pkg;

  localparam int DEF_CNT_WIDTH   = 16;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT     = 65535;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } meter_state_e;

endpackage

// File: rtl/clk_edge_sync.sv
// Synchronizes the asynchronous clk_in into clk and emits one-cycle rise/fall pulses.
module clk_edge_sync
  import clk_meter_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      sync_d <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_in};
      sync_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~sync_d;
  assign fall = ~sync_q[SYNC_STAGES-1] & sync_d;

endmodule

// File: rtl/clk_period_meter.sv
// Measures clk_in period and high time in clk cycles, with a sticky loss flag.
// Define CLK_PERIOD_METER_DUTY_EN to build the high-time path; otherwise high_time reads 0.
//
// state   | meaning
// IDLE    | disabled; waits for en
// ARM     | waiting for the first rise to start a rise-to-rise interval
// MEASURE | interval running; next rise publishes period/high_time
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clk_in,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 valid,
  output logic                 lost
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("clk_period_meter: SYNC_STAGES must be in 2..4");
  end
  if (TIMEOUT < 2 || longint'(TIMEOUT) > ((longint'(1) << CNT_WIDTH) - 1)) begin : g_bad_timeout
    $error("clk_period_meter: TIMEOUT must be in 2..2^CNT_WIDTH-1");
  end

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  meter_state_e         state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 rise, fall;
  logic                 at_timeout;
  logic                 cnt_load, cnt_inc, take_sample, flag_loss, clear_loss;
`ifdef CLK_PERIOD_METER_DUTY_EN
  logic                 hi_capture;
  logic [CNT_WIDTH-1:0] hi_cnt;
`else
  logic                 unused_fall;
  assign unused_fall = fall;
`endif

  clk_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .clk_in(clk_in),
    .rise  (rise),
    .fall  (fall)
  );

  assign at_timeout = (cnt == TIMEOUT_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = ARM;
        ARM:     if (rise) state_nxt = MEASURE;
        MEASURE: if (!rise && at_timeout) state_nxt = ARM;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A rise always beats a simultaneous timeout.
  always_comb begin
    cnt_load    = 1'b0;
    cnt_inc     = 1'b0;
    take_sample = 1'b0;
    flag_loss   = 1'b0;
    clear_loss  = 1'b0;
`ifdef CLK_PERIOD_METER_DUTY_EN
    hi_capture  = 1'b0;
`endif
    if (!en) begin
      clear_loss = 1'b0 | 1'b1;
    end else begin
      case (state)
        IDLE: cnt_load = 1'b1;
        ARM: begin
          if (rise) begin
            cnt_load = 1'b1;
          end else if (at_timeout) begin
            cnt_load  = 1'b1;
            flag_loss = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        MEASURE: begin
`ifdef CLK_PERIOD_METER_DUTY_EN
          hi_capture = fall;
`endif
          if (rise) begin
            cnt_load    = 1'b1;
            take_sample = 1'b1;
          end else if (at_timeout) begin
            cnt_load  = 1'b1;
            flag_loss = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default: cnt_load = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      period <= '0;
      valid  <= 1'b0;
      lost   <= 1'b0;
    end else begin
      if (cnt_load)     cnt <= CNT_ONE;
      else if (cnt_inc) cnt <= cnt + CNT_ONE;
      valid <= take_sample;
      if (take_sample) period <= cnt;
      if (clear_loss || take_sample) lost <= 1'b0;
      else if (flag_loss)            lost <= 1'b1;
    end
  end

`ifdef CLK_PERIOD_METER_DUTY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_cnt    <= '0;
      high_time <= '0;
    end else begin
      if (hi_capture)  hi_cnt    <= cnt;
      if (take_sample) high_time <= hi_cnt;
    end
  end
`else
  assign high_time = '0;
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter against a timestamp-based reference model.
module tb_clk_period_meter;

  localparam int CW = 16;
  localparam int SS = 2;
  localparam int TO = 20;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          en     = 1'b0;
  logic          clk_in = 1'b0;
  logic [CW-1:0] period, high_time;
  logic          valid, lost;

  clk_period_meter #(
    .CNT_WIDTH  (CW),
    .SYNC_STAGES(SS),
    .TIMEOUT    (TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clk_in   (clk_in),
    .period   (period),
    .high_time(high_time),
    .valid    (valid),
    .lost     (lost)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  // clk_in waveform: period wp clk cycles, high for the first wh of them
  int wp = 4, wh = 2, ph = 0;
  bit hold_low = 1'b0;
  bit duty_en;

  // reference model: timestamps of the last counter reload and detected fall
  bit            q[$];
  int            mode;   // 0 disabled, 1 waiting for first rise, 2 interval open
  int            t_ref;
  int            hi;
  bit            m_valid, m_lost;
  logic [CW-1:0] m_period, m_high;

  function automatic logic [CW-1:0] exp_high();
    return duty_en ? m_high : '0;
  endfunction

  task automatic model_reset();
    q.delete();
    for (int k = 0; k < SS + 1; k++) q.push_back(1'b0);
    mode = 0; t_ref = 0; hi = 0;
    m_valid = 1'b0; m_lost = 1'b0; m_period = '0; m_high = '0;
  endtask

  // The meter reacts to a clk_in edge SS clk edges after the edge that first samples it.
  task automatic model_edge();
    bit r, f;
    int sz, n;
    if (!rst_n) return;
    n = cyc;
    q.push_back(clk_in);
    if (q.size() > SS + 2) void'(q.pop_front());
    sz = q.size();
    r = q[sz-1-SS] & ~q[sz-2-SS];
    f = ~q[sz-1-SS] & q[sz-2-SS];
    if (!en) begin
      mode = 0; m_valid = 1'b0; m_lost = 1'b0;
    end else if (mode == 0) begin
      mode = 1; t_ref = n; m_valid = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (f && mode == 2) hi = n - t_ref;
      if (r) begin
        if (mode == 2) begin
          m_valid = 1'b1; m_period = CW'(n - t_ref); m_high = CW'(hi); m_lost = 1'b0;
        end
        mode = 2; t_ref = n;
      end else if (n - t_ref == TO) begin
        m_lost = 1'b1; mode = 1; t_ref = n;
      end
    end
  endtask

  task automatic cycle();
    clk_in = hold_low ? 1'b0 : (ph < wh);
    ph = (ph + 1) % wp;
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    en = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    compared++; if (period !== '0)    begin mismatched++; $display("FAIL reset_period got %0d want 0", period); end
    compared++; if (high_time !== '0) begin mismatched++; $display("FAIL reset_high got %0d want 0", high_time); end
    compared++; if (valid !== 1'b0)   begin mismatched++; $display("FAIL reset_valid got %b want 0", valid); end
    compared++; if (lost !== 1'b0)    begin mismatched++; $display("FAIL reset_lost got %b want 0", lost); end
    en = 1'b0;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_div4();
    int first_v = -1, last_v = -1;
    wp = 4; wh = 2; ph = 0; en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      compared++;
      if ({valid, period, high_time, lost} !== {m_valid, m_period, exp_high(), m_lost}) begin
        mismatched++;
        $display("FAIL div4 cyc %0d got v=%b p=%0d h=%0d l=%b want v=%b p=%0d h=%0d l=%b",
                 i, valid, period, high_time, lost, m_valid, m_period, exp_high(), m_lost);
      end
      if (valid) begin
        if (last_v >= 0) begin
          compared++;
          if (i - last_v != 4) begin mismatched++; $display("FAIL div4_spacing got %0d want 4", i - last_v); end
        end
        if (first_v < 0) first_v = i;
        last_v = i;
      end
    end
    compared++; if (first_v != SS + 4) begin mismatched++; $display("FAIL div4_first_valid got %0d want %0d", first_v, SS + 4); end
    compared++; if (period !== CW'(4)) begin mismatched++; $display("FAIL div4_period got %0d want 4", period); end
    compared++;
    if (high_time !== (duty_en ? CW'(2) : CW'(0))) begin
      mismatched++; $display("FAIL div4_high got %0d want %0d", high_time, duty_en ? 2 : 0);
    end
    compared++; if (lost !== 1'b0) begin mismatched++; $display("FAIL div4_lost got %b want 0", lost); end
  endtask

  task automatic test_div6();
    wp = 6; wh = 3; ph = 0;
    for (int i = 0; i < 60; i++) begin
      cycle();
      compared++;
      if ({valid, period, high_time, lost} !== {m_valid, m_period, exp_high(), m_lost}) begin
        mismatched++;
        $display("FAIL div6 cyc %0d got v=%b p=%0d h=%0d l=%b want v=%b p=%0d h=%0d l=%b",
                 i, valid, period, high_time, lost, m_valid, m_period, exp_high(), m_lost);
      end
    end
    compared++; if (period !== CW'(6)) begin mismatched++; $display("FAIL div6_period got %0d want 6", period); end
    compared++;
    if (high_time !== (duty_en ? CW'(3) : CW'(0))) begin
      mismatched++; $display("FAIL div6_high got %0d want %0d", high_time, duty_en ? 3 : 0);
    end
  endtask

  task automatic test_timeout();
    int last_v = -1, lost_at = -1, first_v = -1, start;
    bit prev_lost;
    wp = 4; wh = 2; ph = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 20) hold_low = 1'b1;
      cycle();
      compared++;
      if ({valid, period, high_time, lost} !== {m_valid, m_period, exp_high(), m_lost}) begin
        mismatched++;
        $display("FAIL timeout cyc %0d got v=%b p=%0d h=%0d l=%b want v=%b p=%0d h=%0d l=%b",
                 i, valid, period, high_time, lost, m_valid, m_period, exp_high(), m_lost);
      end
      if (valid) last_v = cyc;
      if (lost && lost_at < 0) lost_at = cyc;
    end
    compared++; if (lost_at < 0 || lost_at - last_v != TO) begin mismatched++; $display("FAIL timeout_delay got %0d want %0d", lost_at - last_v, TO); end
    compared++; if (period !== CW'(4)) begin mismatched++; $display("FAIL timeout_period_held got %0d want 4", period); end
    hold_low = 1'b0; ph = 0; start = cyc; prev_lost = lost;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (valid && first_v < 0) begin
        first_v = cyc - start;
        compared++;
        if (lost !== 1'b0 || prev_lost !== 1'b1) begin
          mismatched++; $display("FAIL restart_lost_clear got before=%b at=%b want 1/0", prev_lost, lost);
        end
      end
      prev_lost = lost;
    end
    compared++; if (first_v != SS + 5) begin mismatched++; $display("FAIL restart_first_valid got %0d want %0d", first_v, SS + 5); end
  endtask

  task automatic test_rise_at_timeout();
    int nv = 0;
    wp = TO; wh = TO / 2; ph = 0;
    for (int i = 0; i < 70; i++) begin
      cycle();
      compared++;
      if ({valid, period, high_time, lost} !== {m_valid, m_period, exp_high(), m_lost}) begin
        mismatched++;
        $display("FAIL edge_to cyc %0d got v=%b p=%0d h=%0d l=%b want v=%b p=%0d h=%0d l=%b",
                 i, valid, period, high_time, lost, m_valid, m_period, exp_high(), m_lost);
      end
      if (valid) begin
        nv++;
        if (nv >= 2) begin
          compared++;
          if (period !== CW'(TO) || lost !== 1'b0) begin
            mismatched++; $display("FAIL rise_at_timeout got p=%0d l=%b want p=%0d l=0", period, lost, TO);
          end
        end
      end
    end
    compared++; if (nv < 3) begin mismatched++; $display("FAIL rise_at_timeout_count got %0d want >=3", nv); end
  endtask

  task automatic test_en_drop();
    int seen = 0;
    logic [CW-1:0] p0;
    wp = 6; wh = 3; ph = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      cycle();
      if (i > 14 && valid) seen = 1;
    end
    compared++; if (seen == 0) begin mismatched++; $display("FAIL en_drop_lock got no valid want valid"); end
    cycle(); cycle();
    p0 = period;
    en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      compared++;
      if (valid !== 1'b0 || period !== p0 || lost !== 1'b0 ||
          {valid, period, high_time, lost} !== {m_valid, m_period, exp_high(), m_lost}) begin
        mismatched++;
        $display("FAIL en_drop cyc %0d got v=%b p=%0d l=%b want v=0 p=%0d l=0", i, valid, period, lost, p0);
      end
    end
    en = 1'b1;
  endtask

  task automatic test_async_reset();
    wp = 4; wh = 2; ph = 0;
    for (int i = 0; i < 20; i++) cycle();
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if ({valid, period, high_time, lost} !== {1'b0, CW'(0), CW'(0), 1'b0}) begin
      mismatched++;
      $display("FAIL async_reset got v=%b p=%0d h=%0d l=%b want all 0", valid, period, high_time, lost);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cycle();
      compared++;
      if ({valid, period, high_time, lost} !== {m_valid, m_period, exp_high(), m_lost}) begin
        mismatched++;
        $display("FAIL post_reset cyc %0d got v=%b p=%0d h=%0d l=%b want v=%b p=%0d h=%0d l=%b",
                 i, valid, period, high_time, lost, m_valid, m_period, exp_high(), m_lost);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      wp = $urandom_range(TO + 4, 2);
      wh = $urandom_range(wp - 1, 1);
      ph = $urandom_range(wp - 1, 0);
      for (int i = 0; i < 3 * wp + 10; i++) begin
        en = ($urandom_range(39, 0) != 0);
        cycle();
        compared++;
        if ({valid, period, high_time, lost} !== {m_valid, m_period, exp_high(), m_lost}) begin
          mismatched++;
          $display("FAIL random p%0d/h%0d cyc %0d got v=%b p=%0d h=%0d l=%b want v=%b p=%0d h=%0d l=%b",
                   wp, wh, i, valid, period, high_time, lost, m_valid, m_period, exp_high(), m_lost);
        end
      end
    end
    en = 1'b1;
  endtask

  initial begin
`ifdef CLK_PERIOD_METER_DUTY_EN
    duty_en = 1'b1;
`else
    duty_en = 1'b0;
`endif
    model_reset();
    @(negedge clk);
    test_reset();
    test_div4();
    test_div6();
    test_timeout();
    test_rise_at_timeout();
    test_en_drop();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
